// File: rtl/sensor_init_sequencer.sv
// Walks a table of sensor register writes and hands each one to the I2C register-write
// engine, with per-entry retries, inter-write spacing and a response watchdog.
module sensor_init_sequencer #(
  parameter logic [6:0] DEV_ADDR        = 7'h21,
  parameter int         NUM_ENTRIES     = 16,
  parameter int         MAX_RETRIES     = 3,
  parameter int         GAP_CYCLES      = 1000,
  parameter int         WATCHDOG_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic [6:0]  wr_dev_address,
  output logic [7:0]  wr_reg_address,
  output logic [7:0]  wr_data,
  output logic        wr_start,
  input  logic        wr_done,
  input  logic        wr_fail,
  output logic        init_busy,
  output logic        init_done,
  output logic        init_error,
  output logic [7:0]  error_index,
  output logic [3:0]  retry_count,
  output logic [2:0]  fsm_state
);

  localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  localparam logic [7:0]     LAST_IDX  = 8'(NUM_ENTRIES - 1);
  localparam logic [3:0]     MAX_RETRY = 4'(MAX_RETRIES);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(WATCHDOG_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  state_t         state_q;
  logic [7:0]     index_q;
  logic [3:0]     retry_q;
  logic [WDW-1:0] wdog_q;
  logic [GW-1:0]  gap_q;
  logic           refetch_q;
  logic           wr_start_q;
  logic [6:0]     dev_q;
  logic [7:0]     reg_q;
  logic [7:0]     data_q;
  logic           busy_q;
  logic           done_q;
  logic           error_q;
  logic [7:0]     err_idx_q;

  // Engine handshake: wr_start is a one-cycle request carrying the latched address/data;
  // the engine answers later with wr_done and/or wr_fail, which are only honoured in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      index_q    <= 8'd0;
      retry_q    <= 4'd0;
      wdog_q     <= '0;
      gap_q      <= '0;
      refetch_q  <= 1'b0;
      wr_start_q <= 1'b0;
      dev_q      <= DEV_ADDR;
      reg_q      <= 8'd0;
      data_q     <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= 8'd0;
    end else begin
      wr_start_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (init_start) begin
            state_q   <= S_FETCH;
            index_q   <= 8'd0;
            retry_q   <= 4'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= 8'd0;
            busy_q    <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          reg_q   <= rom_data[15:8];
          data_q  <= rom_data[7:0];
          dev_q   <= DEV_ADDR;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          wr_start_q <= 1'b1;
          wdog_q     <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + WDW'(1);
          // A simultaneous done+fail is resolved as a failure.
          if (wr_fail || (wdog_q == WD_LAST)) begin
            if (retry_q < MAX_RETRY) begin
              retry_q   <= retry_q + 4'd1;
              refetch_q <= 1'b0;
              gap_q     <= '0;
              state_q   <= S_GAP;
            end else begin
              err_idx_q <= index_q;
              error_q   <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= S_ERROR;
            end
          end else if (wr_done) begin
            retry_q <= 4'd0;
            if (index_q == LAST_IDX) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              index_q   <= index_q + 8'd1;
              refetch_q <= 1'b1;
              gap_q     <= '0;
              state_q   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= refetch_q ? S_FETCH : S_ISSUE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr       = index_q;
  assign wr_dev_address = dev_q;
  assign wr_reg_address = reg_q;
  assign wr_data        = data_q;
  assign wr_start       = wr_start_q;
  assign init_busy      = busy_q;
  assign init_done      = done_q;
  assign init_error     = error_q;
  assign error_index    = err_idx_q;
  assign retry_count    = retry_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_sensor_init_sequencer.sv
// Bench for sensor_init_sequencer: a plan-level model predicts every write, its timing
// and the final outcome; the bench plays the ROM and the register-write engine.
`timescale 1ns/1ps
module tb_sensor_init_sequencer;

  localparam int         NUM  = 3;
  localparam int         MAXR = 3;
  localparam int         GAP  = 4;
  localparam int         WD   = 50;
  localparam logic [6:0] DEV  = 7'h21;

  localparam int K_DONE = 0;
  localparam int K_FAIL = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_start = 1'b0;
  logic        wr_done = 1'b0;
  logic        wr_fail = 1'b0;
  logic [15:0] rom_data = 16'h0;
  logic [7:0]  rom_addr, wr_reg_address, wr_data, error_index;
  logic [6:0]  wr_dev_address;
  logic        wr_start, init_busy, init_done, init_error;
  logic [3:0]  retry_count;
  logic [2:0]  fsm_state;

  logic [15:0] rom [0:255];
  logic [22:0] exp_q[$];
  int entry_q[$], attempt_q[$], kind_q[$], delay_q[$], hold_q[$];
  int force_kind [0:NUM-1][0:MAXR];
  int force_delay, force_hold;
  bit exp_done, exp_error;
  int exp_err_idx;
  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  sensor_init_sequencer #(
    .DEV_ADDR(DEV), .NUM_ENTRIES(NUM), .MAX_RETRIES(MAXR),
    .GAP_CYCLES(GAP), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_dev_address(wr_dev_address), .wr_reg_address(wr_reg_address),
    .wr_data(wr_data), .wr_start(wr_start), .wr_done(wr_done), .wr_fail(wr_fail),
    .init_busy(init_busy), .init_done(init_done), .init_error(init_error),
    .error_index(error_index), .retry_count(retry_count), .fsm_state(fsm_state)
  );

  // clock / reset / ROM
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset = 1'b1; init_start = 1'b0; wr_done = 1'b0; wr_fail = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: expand the table and per-attempt engine responses into a write plan
  task automatic set_force(input int k);
    for (int e = 0; e < NUM; e++)
      for (int a = 0; a <= MAXR; a++) force_kind[e][a] = k;
  endtask

  function automatic int pick_kind();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return K_DONE;
    if (r <= 7) return K_FAIL;
    if (r == 8) return K_BOTH;
    return K_NONE;
  endfunction

  task automatic build_plan();
    int k;
    exp_q.delete(); entry_q.delete(); attempt_q.delete();
    kind_q.delete(); delay_q.delete(); hold_q.delete();
    exp_done = 1'b0; exp_error = 1'b0; exp_err_idx = 0;
    for (int e = 0; e < NUM; e++) begin
      for (int a = 0; a <= MAXR; a++) begin
        k = (force_kind[e][a] >= 0) ? force_kind[e][a] : pick_kind();
        exp_q.push_back({DEV, rom[e]});
        entry_q.push_back(e);
        attempt_q.push_back(a);
        kind_q.push_back(k);
        delay_q.push_back((force_delay > 0) ? force_delay : int'($urandom_range(1, 12)));
        hold_q.push_back((force_hold > 0) ? force_hold : int'($urandom_range(1, 5)));
        if (k == K_DONE) break;
        if (a == MAXR) begin
          exp_error = 1'b1;
          exp_err_idx = e;
        end
      end
      if (exp_error) break;
    end
    if (!exp_error) exp_done = 1'b1;
  endtask

  // driver: engine model answering each wr_start according to the plan
  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b1;
    while (wr_start !== 1'b1) begin
      if (budget == 0) begin
        ok = 1'b0;
        return;
      end
      budget--;
      step();
    end
  endtask

  task automatic run_sequence(input bit poke_gap);
    logic [22:0] w;
    int e, a, k, d, h, s, n, exp_cyc, b, extra;
    bit ok;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    check("busy_after_start", init_busy, 1);
    exp_cyc = cyc + 3;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      e = entry_q.pop_front(); a = attempt_q.pop_front(); k = kind_q.pop_front();
      d = delay_q.pop_front(); h = hold_q.pop_front();
      wait_start(WD + GAP + 20, ok);
      check("start_seen", ok, 1);
      if (!ok) begin
        apply_reset();
        return;
      end
      s = cyc;
      check("start_cycle", s, exp_cyc);
      check("write_tuple", 32'({wr_dev_address, wr_reg_address, wr_data}), 32'(w));
      check("rom_addr", rom_addr, e);
      check("retry_count", retry_count, a);
      step();
      check("start_pulse", wr_start, 0);
      if (k == K_NONE) begin
        exp_cyc = s + WD + GAP + 1;
      end else begin
        repeat (d - 1) step();
        wr_done = (k != K_FAIL);
        wr_fail = (k != K_DONE);
        step();
        n = cyc;
        if (k == K_DONE) repeat (h - 1) step();
        wr_done = 1'b0;
        wr_fail = 1'b0;
        exp_cyc = n + GAP + ((k == K_DONE) ? 3 : 1);
        if (poke_gap && exp_q.size() > 0) begin
          init_start = 1'b1;
          step();
          init_start = 1'b0;
        end
      end
    end
    b = 100;
    while (init_busy && b > 0) begin
      step();
      b--;
    end
    check("busy_end", init_busy, 0);
    check("init_done", init_done, exp_done);
    check("init_error", init_error, exp_error);
    if (exp_error) check("error_index", error_index, exp_err_idx);
    extra = 0;
    repeat (30) begin
      step();
      if (wr_start) extra++;
    end
    check("no_extra_start", extra, 0);
  endtask

  initial begin
    bit ok;
    int extra;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h40D0;
    force_delay = 0; force_hold = 0;

    apply_reset();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_dev", wr_dev_address, DEV);
    check("rst_reg", wr_reg_address, 0);
    check("rst_data", wr_data, 0);
    check("rst_start", wr_start, 0);
    check("rst_busy", init_busy, 0);
    check("rst_done", init_done, 0);
    check("rst_error", init_error, 0);
    check("rst_err_idx", error_index, 0);
    check("rst_retry", retry_count, 0);

    // three-entry happy path, 10-cycle response latency
    set_force(K_DONE); force_delay = 10; force_hold = 1;
    build_plan(); run_sequence(1'b0);
    force_delay = 0; force_hold = 0;

    // single retry on entry 1, with init_start poked during GAP
    set_force(K_DONE); force_kind[1][0] = K_FAIL;
    build_plan(); run_sequence(1'b1);

    // retry exhaustion on entry 2, then a clean restart from index 0
    set_force(K_DONE);
    for (int a = 0; a <= MAXR; a++) force_kind[2][a] = K_FAIL;
    build_plan(); run_sequence(1'b0);
    set_force(K_DONE);
    build_plan(); run_sequence(1'b0);

    // watchdog on the first attempt of entry 0
    set_force(K_DONE); force_kind[0][0] = K_NONE;
    build_plan(); run_sequence(1'b0);

    // simultaneous done+fail, and wr_done held for 5 cycles
    set_force(K_DONE); force_kind[1][0] = K_BOTH; force_hold = 5;
    build_plan(); run_sequence(1'b1);
    force_hold = 0;

    // randomized tables and responses
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NUM; i++) rom[i] = 16'($urandom);
      set_force(-1);
      build_plan();
      run_sequence(r[0]);
    end

    // reset while waiting for a response
    init_start = 1'b1; step(); init_start = 1'b0;
    wait_start(20, ok);
    check("rst_wait_start_seen", ok, 1);
    repeat (3) step();
    check("rst_wait_busy_before", init_busy, 1);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_wait_busy", init_busy, 0);
    check("rst_wait_start", wr_start, 0);
    check("rst_wait_done", init_done, 0);
    check("rst_wait_error", init_error, 0);
    check("rst_wait_retry", retry_count, 0);
    check("rst_wait_rom_addr", rom_addr, 0);
    check("rst_wait_dev", wr_dev_address, DEV);
    extra = 0;
    repeat (WD + 10) begin
      step();
      if (wr_start || init_busy) extra++;
    end
    check("rst_wait_quiet", extra, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
